// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader with core reset hold
module imem_loader #(
   parameter int MAX_WORDS  = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic [15:0]           words_loaded,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  cpu_rst_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] n_words;
   logic [1:0]  byte_idx;
   logic        xfer;
   logic [15:0] len_full;

   assign xfer     = in_valid & in_ready;
   // Length as it will be once the high byte in flight is latched.
   assign len_full = {in_data, n_words[7:0]};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status outputs; every output is a pure function of state.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      wr_en     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      cpu_rst_n = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               if (len_full == 16'd0)                   state_nxt = S_DONE;
               else if (len_full > 16'(MAX_WORDS))      state_nxt = S_ERROR;
               else                                     state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && byte_idx == 2'd3) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            wr_en = 1'b1;
            busy  = 1'b1;
            if (words_loaded + 16'd1 == n_words) state_nxt = S_DONE;
            else                                 state_nxt = S_DATA;
         end
         S_DONE: begin
            done      = 1'b1;
            cpu_rst_n = 1'b1;
            if (start) state_nxt = S_LEN_LO;
         end
         S_ERROR: begin
            error = 1'b1;
            if (start) state_nxt = S_LEN_LO;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: length capture, little-endian word assembly, address and count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_words      <= 16'd0;
         byte_idx     <= 2'd0;
         wr_addr      <= '0;
         wr_data      <= 32'd0;
         words_loaded <= 16'd0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  words_loaded <= 16'd0;
                  wr_addr      <= '0;
                  byte_idx     <= 2'd0;
               end
            end
            S_LEN_LO: begin
               if (xfer) n_words[7:0] <= in_data;
            end
            S_LEN_HI: begin
               if (xfer) n_words[15:8] <= in_data;
            end
            S_DATA: begin
               if (xfer) begin
                  wr_data[{byte_idx, 3'b000} +: 8] <= in_data;
                  byte_idx                         <= byte_idx + 2'd1;
                  // Address is set from the count of completed words, so it
                  // never runs past the last word written.
                  if (byte_idx == 2'd3) wr_addr <= ADDR_WIDTH'(words_loaded) << 2;
               end
            end
            S_WRITE: begin
               words_loaded <= words_loaded + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [15:0] words_loaded;
   logic        busy;
   logic        done;
   logic        error;
   logic        cpu_rst_n;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int ready_bad = 0;

   imem_loader #(.MAX_WORDS(16), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .words_loaded(words_loaded),
      .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
   );

   always #5 clk = ~clk;

   // Record every memory write; in_ready must be low while writing.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wa.push_back(wr_addr);
         wd.push_back(wr_data);
         if (in_ready !== 1'b0) ready_bad++;
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         vectors++; miscompares++;
         $display("FAIL send_byte timeout: in_ready=%b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_settle();
      for (int c = 0; c < 20 && done !== 1'b1 && error !== 1'b1; c++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(negedge clk);
      vectors++;
      if ({in_ready, wr_en, busy, done, error, cpu_rst_n} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b required 000000",
                  {in_ready, wr_en, busy, done, error, cpu_rst_n});
      end
      vectors++;
      if (wr_addr !== 32'd0 || wr_data !== 32'd0 || words_loaded !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_regs: addr=%h data=%h words=%0d required 0", wr_addr, wr_data, words_loaded);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_hold: busy=%b in_ready=%b required 0 0", busy, in_ready);
      end
   endtask

   task automatic run_two_word(input string name, input int with_gaps);
      logic [7:0] s [10] = '{8'h02, 8'h00, 8'h10, 8'h03, 8'h10, 8'h00, 8'h90, 8'h03, 8'h00, 8'h00};
      wa.delete(); wd.delete(); ready_bad = 0;
      pulse_start();
      for (int i = 0; i < 10; i++) send_byte(s[i], with_gaps ? (i % 4) : 0);
      wait_settle();
      vectors++;
      if (wa.size() != 2) begin
         miscompares++;
         $display("FAIL %s write_count: got %0d required 2", name, wa.size());
      end else begin
         vectors++;
         if (wa[0] !== 32'h0 || wd[0] !== 32'h00100310) begin
            miscompares++;
            $display("FAIL %s write0: got (%h,%h) required (00000000,00100310)", name, wa[0], wd[0]);
         end
         vectors++;
         if (wa[1] !== 32'h4 || wd[1] !== 32'h00000390) begin
            miscompares++;
            $display("FAIL %s write1: got (%h,%h) required (00000004,00000390)", name, wa[1], wd[1]);
         end
      end
      vectors++;
      if (done !== 1'b1 || cpu_rst_n !== 1'b1 || words_loaded !== 16'd2 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s final: done=%b cpu_rst_n=%b words=%0d busy=%b required 1 1 2 0",
                  name, done, cpu_rst_n, words_loaded, busy);
      end
      vectors++;
      if (ready_bad != 0) begin
         miscompares++;
         $display("FAIL %s ready_in_write: got %0d cycles required 0", name, ready_bad);
      end
   endtask

   task automatic test_basic();
      run_two_word("basic", 0);
   endtask

   task automatic test_gaps();
      run_two_word("gaps", 1);
   endtask

   task automatic test_zero_len();
      wa.delete(); wd.delete();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      wait_settle();
      vectors++;
      if (wa.size() != 0 || done !== 1'b1 || cpu_rst_n !== 1'b1 || words_loaded !== 16'd0) begin
         miscompares++;
         $display("FAIL zero_len: writes=%0d done=%b cpu_rst_n=%b words=%0d required 0 1 1 0",
                  wa.size(), done, cpu_rst_n, words_loaded);
      end
   endtask

   task automatic test_too_long();
      wa.delete(); wd.delete();
      pulse_start();
      send_byte(8'h11, 0);
      send_byte(8'h00, 0);
      wait_settle();
      repeat (3) @(negedge clk);
      vectors++;
      if (error !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0 || in_ready !== 1'b0 || wa.size() != 0) begin
         miscompares++;
         $display("FAIL too_long: error=%b done=%b cpu_rst_n=%b in_ready=%b writes=%0d required 1 0 0 0 0",
                  error, done, cpu_rst_n, in_ready, wa.size());
      end
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hEF, 0);
      send_byte(8'hBE, 0);
      send_byte(8'hAD, 0);
      send_byte(8'hDE, 0);
      wait_settle();
      vectors++;
      if (error !== 1'b0 || done !== 1'b1 || wa.size() != 1) begin
         miscompares++;
         $display("FAIL recover: error=%b done=%b writes=%0d required 0 1 1", error, done, wa.size());
      end else begin
         vectors++;
         if (wa[0] !== 32'h0 || wd[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL recover_write: got (%h,%h) required (00000000,deadbeef)", wa[0], wd[0]);
         end
      end
   endtask

   task automatic test_max_len();
      int bad;
      wa.delete(); wd.delete();
      pulse_start();
      send_byte(8'h10, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 64; i++) send_byte(8'(i), 0);
      wait_settle();
      vectors++;
      if (wa.size() != 16 || done !== 1'b1 || words_loaded !== 16'd16) begin
         miscompares++;
         $display("FAIL max_len: writes=%0d done=%b words=%0d required 16 1 16", wa.size(), done, words_loaded);
      end else begin
         vectors++;
         if (wa[15] !== 32'h3C) begin
            miscompares++;
            $display("FAIL max_last_addr: got %h required 0000003c", wa[15]);
         end
         bad = 0;
         for (int k = 0; k < 16; k++) begin
            if (wa[k] !== 32'(4 * k) ||
                wd[k] !== {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}) bad++;
         end
         vectors++;
         if (bad != 0) begin
            miscompares++;
            $display("FAIL max_words_content: got %0d bad words required 0", bad);
         end
      end
   endtask

   task automatic test_back_to_back();
      wa.delete(); wd.delete();
      pulse_start();
      vectors++;
      if (done !== 1'b0 || cpu_rst_n !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL restart: done=%b cpu_rst_n=%b busy=%b required 0 0 1", done, cpu_rst_n, busy);
      end
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      pulse_start();
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      wait_settle();
      vectors++;
      if (wa.size() != 1 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_start: writes=%0d done=%b required 1 1", wa.size(), done);
      end else begin
         vectors++;
         if (wa[0] !== 32'h0 || wd[0] !== 32'h44332211) begin
            miscompares++;
            $display("FAIL busy_start_write: got (%h,%h) required (00000000,44332211)", wa[0], wd[0]);
         end
      end
   endtask

   task automatic test_mid_reset();
      wa.delete(); wd.delete();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({in_ready, wr_en, busy, done, error, cpu_rst_n} !== 6'b0 ||
          wr_data !== 32'd0 || words_loaded !== 16'd0) begin
         miscompares++;
         $display("FAIL mid_reset: flags=%b data=%h words=%0d required 000000 0 0",
                  {in_ready, wr_en, busy, done, error, cpu_rst_n}, wr_data, words_loaded);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send_byte_noreq(8'hCC);
      vectors++;
      if (wa.size() != 0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL after_reset: writes=%0d busy=%b in_ready=%b done=%b required 0 0 0 0",
                  wa.size(), busy, in_ready, done);
      end
   endtask

   // Offer bytes with no expectation of acceptance, as an idle loader must ignore them.
   task automatic send_byte_noreq(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      repeat (8) @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_zero_len();
      test_too_long();
      test_max_len();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
